// File: rtl/xt_kbd_pkg.sv
// Shared types and constants for the XT keyboard front end.
package xt_kbd_pkg;

   localparam int unsigned FRAME_DATA_BITS = 8;
   localparam int unsigned BIT_CNT_W       = $clog2(FRAME_DATA_BITS);

   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   localparam logic [FRAME_DATA_BITS-1:0] SCAN_RESET = 8'h00;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      PARITY = 3'd2,
      STOP   = 3'd3,
      HOLD   = 3'd4
   } kbd_state_e;

   // Odd parity holds when data plus parity bit contain an odd number of ones.
   function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] d,
                                          input logic                       p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/xt_kbd_sync_edge.sv
// Synchronises the keyboard clock/data lines and flags keyboard clock falling edges.
module xt_kbd_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic kbd_clk,
   input  logic kbd_data,
   output logic data_s,
   output logic clk_fe_c
);

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   clk_prev_q, clk_prev_d;

   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], kbd_clk};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], kbd_data};
      clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
   end

   // Lines idle high, so the chains reset to 1 to avoid a spurious edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         clk_prev_q  <= clk_prev_d;
      end
   end

   assign data_s   = data_sync_q[SYNC_STAGES-1];
   assign clk_fe_c = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/xt_kbd_interface.sv
// XT keyboard receiver feeding PPI port A and IRQ1.
// Optional odd-parity enforcement with sticky parity_err: define XT_KBD_PARITY_CHECK_EN.
module xt_kbd_interface
   import xt_kbd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       kbd_clk,
   input  logic       kbd_data,
   input  logic       pb7_clear,
   input  logic       pb6_clk_en,
   input  logic [7:0] sw,
   output logic [7:0] pa,
   output logic       irq1,
   output logic       kbd_clk_hold
`ifdef XT_KBD_PARITY_CHECK_EN
  ,output logic       parity_err
`endif
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_DATA_BITS - 1);

   logic data_s;
   logic clk_fe_c;

   xt_kbd_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk      (clk),
      .reset    (reset),
      .kbd_clk  (kbd_clk),
      .kbd_data (kbd_data),
      .data_s   (data_s),
      .clk_fe_c (clk_fe_c)
   );

   kbd_state_e                 state_q, state_d;
   logic [BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
   logic [FRAME_DATA_BITS-1:0] scan_q, scan_d;
   logic                       irq_q, irq_d;
   logic [TMO_W-1:0]           tmo_q, tmo_d;
   logic                       in_frame;
`ifdef XT_KBD_PARITY_CHECK_EN
   logic                       par_q, par_d;
   logic                       perr_q, perr_d;
`endif

   assign in_frame = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);

   // Next-state: clear > inhibit > timeout > keyboard clock edge.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      scan_d    = scan_q;
      irq_d     = irq_q;
      tmo_d     = tmo_q;
`ifdef XT_KBD_PARITY_CHECK_EN
      par_d     = par_q;
      perr_d    = perr_q;
`endif
      if (pb7_clear) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         tmo_d     = '0;
         irq_d     = 1'b0;
`ifdef XT_KBD_PARITY_CHECK_EN
         perr_d    = 1'b0;
`endif
      end else if (!pb6_clk_en) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         tmo_d     = '0;
      end else if (in_frame && (tmo_q == TMO_LAST)) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         tmo_d     = '0;
      end else if (clk_fe_c && (state_q != HOLD)) begin
         tmo_d = '0;
         case (state_q)
            IDLE: begin
               if (data_s == START_LEVEL) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d   = {data_s, shift_q[FRAME_DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
`ifdef XT_KBD_PARITY_CHECK_EN
               par_d   = data_s;
`endif
               state_d = STOP;
            end
            STOP: begin
               state_d   = IDLE;
               bit_cnt_d = '0;
`ifdef XT_KBD_PARITY_CHECK_EN
               if ((data_s == STOP_LEVEL) && odd_parity_ok(shift_q, par_q)) begin
                  scan_d  = shift_q;
                  irq_d   = 1'b1;
                  state_d = HOLD;
               end else if (data_s == STOP_LEVEL) begin
                  perr_d  = 1'b1;
               end
`else
               if (data_s == STOP_LEVEL) begin
                  scan_d  = shift_q;
                  irq_d   = 1'b1;
                  state_d = HOLD;
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end else if (in_frame) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         scan_q    <= SCAN_RESET;
         irq_q     <= 1'b0;
         tmo_q     <= '0;
`ifdef XT_KBD_PARITY_CHECK_EN
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         scan_q    <= scan_d;
         irq_q     <= irq_d;
         tmo_q     <= tmo_d;
`ifdef XT_KBD_PARITY_CHECK_EN
         par_q     <= par_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign pa           = pb7_clear ? sw : scan_q;
   assign irq1         = irq_q;
   assign kbd_clk_hold = (state_q == HOLD) | ~pb6_clk_en;
`ifdef XT_KBD_PARITY_CHECK_EN
   assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_xt_kbd_interface.sv
// Directed self-checking bench for xt_kbd_interface.
module tb_xt_kbd_interface;

   localparam int unsigned TIMEOUT_CYCLES = 4096;

   logic       clk;
   logic       reset;
   logic       kbd_clk;
   logic       kbd_data;
   logic       pb7_clear;
   logic       pb6_clk_en;
   logic [7:0] sw;
   logic [7:0] pa;
   logic       irq1;
   logic       kbd_clk_hold;
`ifdef XT_KBD_PARITY_CHECK_EN
   logic       parity_err;
`endif

   int checks   = 0;
   int failures = 0;

   xt_kbd_interface #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .kbd_clk      (kbd_clk),
      .kbd_data     (kbd_data),
      .pb7_clear    (pb7_clear),
      .pb6_clk_en   (pb6_clk_en),
      .sw           (sw),
      .pa           (pa),
      .irq1         (irq1),
      .kbd_clk_hold (kbd_clk_hold)
`ifdef XT_KBD_PARITY_CHECK_EN
     ,.parity_err   (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One keyboard bit: data set while kbd_clk high, then a low pulse.
   task automatic send_bit(input logic b);
      @(negedge clk) kbd_data = b;
      repeat (3) @(negedge clk);
      kbd_clk = 1'b0;
      repeat (4) @(negedge clk);
      kbd_clk = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(stop);
   endtask

   task automatic pulse_clear();
      @(negedge clk) pb7_clear = 1'b1;
      @(negedge clk) pb7_clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (irq1 !== 1'b0) begin
         failures++; $display("FAIL reset_irq1: got %b want 0", irq1);
      end
      checks++;
      if (pa !== 8'h00) begin
         failures++; $display("FAIL reset_pa: got %h want 00", pa);
      end
      checks++;
      if (kbd_clk_hold !== 1'b0) begin
         failures++; $display("FAIL reset_hold: got %b want 0", kbd_clk_hold);
      end
      sw = 8'h5A; pb7_clear = 1'b1;
      #1;
      checks++;
      if (pa !== 8'h5A) begin
         failures++; $display("FAIL reset_pa_sw: got %h want 5a", pa);
      end
      @(negedge clk) pb7_clear = 1'b0;
   endtask

   task automatic test_frame_error();
      send_frame(8'h1C, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      checks++;
      if (irq1 !== 1'b0) begin
         failures++; $display("FAIL ferr_irq1: got %b want 0", irq1);
      end
      checks++;
      if (pa !== 8'h00) begin
         failures++; $display("FAIL ferr_pa: got %h want 00", pa);
      end
      checks++;
      if (kbd_clk_hold !== 1'b0) begin
         failures++; $display("FAIL ferr_hold: got %b want 0", kbd_clk_hold);
      end
   endtask

   task automatic test_commit_latency();
      logic [7:0] d;
      d = 8'h1C;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(~^d);
      @(negedge clk) kbd_data = 1'b1;
      repeat (3) @(negedge clk);
      kbd_clk = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (irq1 !== 1'b0) begin
         failures++; $display("FAIL lat_irq1_early: got %b want 0", irq1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (irq1 !== 1'b1) begin
         failures++; $display("FAIL lat_irq1: got %b want 1", irq1);
      end
      checks++;
      if (pa !== 8'h1C) begin
         failures++; $display("FAIL lat_pa: got %h want 1c", pa);
      end
      checks++;
      if (kbd_clk_hold !== 1'b1) begin
         failures++; $display("FAIL lat_hold: got %b want 1", kbd_clk_hold);
      end
      repeat (3) @(negedge clk);
      kbd_clk = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_hold_and_clear();
      send_frame(8'h1E, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      checks++;
      if (pa !== 8'h1C || irq1 !== 1'b1) begin
         failures++; $display("FAIL hold_ignore: got pa=%h irq1=%b want pa=1c irq1=1", pa, irq1);
      end
      @(negedge clk) sw = 8'hA5; pb7_clear = 1'b1;
      #1;
      checks++;
      if (pa !== 8'hA5) begin
         failures++; $display("FAIL clear_pa_sw: got %h want a5", pa);
      end
      @(negedge clk) pb7_clear = 1'b0;
      #1;
      checks++;
      if (irq1 !== 1'b0 || kbd_clk_hold !== 1'b0) begin
         failures++; $display("FAIL clear_irq1: got irq1=%b hold=%b want 0 0", irq1, kbd_clk_hold);
      end
      checks++;
      if (pa !== 8'h1C) begin
         failures++; $display("FAIL clear_retain: got %h want 1c", pa);
      end
      send_frame(8'h1E, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (pa !== 8'h1E || irq1 !== 1'b1) begin
         failures++; $display("FAIL after_clear: got pa=%h irq1=%b want pa=1e irq1=1", pa, irq1);
      end
   endtask

   task automatic test_timeout();
      pulse_clear();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
      checks++;
      if (irq1 !== 1'b0 || kbd_clk_hold !== 1'b0) begin
         failures++; $display("FAIL tmo_idle: got irq1=%b hold=%b want 0 0", irq1, kbd_clk_hold);
      end
      send_frame(8'h2A, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (pa !== 8'h2A || irq1 !== 1'b1) begin
         failures++; $display("FAIL tmo_recover: got pa=%h irq1=%b want pa=2a irq1=1", pa, irq1);
      end
   endtask

   task automatic test_timeout_boundary();
      logic [7:0] d;
      d = 8'h35;
      pulse_clear();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      repeat (TIMEOUT_CYCLES - 40) @(negedge clk);
      for (int i = 4; i < 8; i++) send_bit(d[i]);
      send_bit(~^d);
      send_bit(1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (pa !== 8'h35 || irq1 !== 1'b1) begin
         failures++; $display("FAIL tmo_edge: got pa=%h irq1=%b want pa=35 irq1=1", pa, irq1);
      end
   endtask

   task automatic test_inhibit();
      pulse_clear();
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      @(negedge clk) pb6_clk_en = 1'b0;
      #1;
      checks++;
      if (kbd_clk_hold !== 1'b1) begin
         failures++; $display("FAIL inh_hold: got %b want 1", kbd_clk_hold);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (pa !== 8'h35 || irq1 !== 1'b0) begin
         failures++; $display("FAIL inh_keep: got pa=%h irq1=%b want pa=35 irq1=0", pa, irq1);
      end
      pb6_clk_en = 1'b1;
      #1;
      checks++;
      if (kbd_clk_hold !== 1'b0) begin
         failures++; $display("FAIL inh_release: got %b want 0", kbd_clk_hold);
      end
      send_frame(8'h9C, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (pa !== 8'h9C || irq1 !== 1'b1) begin
         failures++; $display("FAIL inh_recover: got pa=%h irq1=%b want pa=9c irq1=1", pa, irq1);
      end
   endtask

`ifdef XT_KBD_PARITY_CHECK_EN
   task automatic test_parity();
      pulse_clear();
      checks++;
      if (parity_err !== 1'b0) begin
         failures++; $display("FAIL par_init: got %b want 0", parity_err);
      end
      send_frame(8'h1C, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (irq1 !== 1'b0 || parity_err !== 1'b1) begin
         failures++; $display("FAIL par_bad: got irq1=%b perr=%b want 0 1", irq1, parity_err);
      end
      pulse_clear();
      checks++;
      if (parity_err !== 1'b0) begin
         failures++; $display("FAIL par_clear: got %b want 0", parity_err);
      end
   endtask
`endif

   initial begin
      reset      = 1'b1;
      kbd_clk    = 1'b1;
      kbd_data   = 1'b1;
      pb7_clear  = 1'b0;
      pb6_clk_en = 1'b1;
      sw         = 8'h00;
      test_reset();
      test_frame_error();
      test_commit_latency();
      test_hold_and_clear();
      test_timeout();
      test_timeout_boundary();
      test_inhibit();
`ifdef XT_KBD_PARITY_CHECK_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
